uart_byte_rx: RTL and testbench

UART_BYTE_RX -- requirements
Module: uart_byte_rx

---
 rtl/uart_byte_rx.sv | 126 ++++++++++++
 tb/tb_uart_byte_rx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - 8N1 UART byte receiver producing IO register write strobes
module uart_byte_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] wr_data,
    output logic       wr_en,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [2:0]      bit_idx, bit_idx_nxt;
    logic [7:0]      shift, shift_nxt;
    logic [7:0]      wr_data_nxt;
    logic            wr_en_nxt, frame_err_nxt;
    logic            rx_meta, rx_s;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        bit_idx_nxt   = bit_idx;
        shift_nxt     = shift;
        wr_data_nxt   = wr_data;
        wr_en_nxt     = 1'b0;
        frame_err_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt = START;
                    cnt_nxt   = '0;
                end
            end
            START: begin
                // Half-bit wait lands every later sample in the middle of its bit.
                if (cnt == HALF_M1) begin
                    cnt_nxt = '0;
                    if (!rx_s) begin
                        state_nxt   = DATA;
                        bit_idx_nxt = 3'd0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_nxt     = '0;
                    shift_nxt   = {rx_s, shift[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_nxt = '0;
                    if (rx_s) begin
                        wr_data_nxt = shift;
                        wr_en_nxt   = 1'b1;
                        state_nxt   = IDLE;
                    end else begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = WAIT_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            WAIT_IDLE: begin
                // Hold off a held-low break line from looking like a new start bit.
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            wr_data   <= 8'h00;
            wr_en     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_meta   <= rx_in;
            rx_s      <= rx_meta;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shift     <= shift_nxt;
            wr_data   <= wr_data_nxt;
            wr_en     <= wr_en_nxt;
            frame_err <= frame_err_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb/tb_uart_byte_rx.sv - directed vector bench for uart_byte_rx
module tb_uart_byte_rx;

    localparam int C = 16;
    localparam int LAT = 155;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_in = 1'b1;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       frame_err;
    logic       busy;

    uart_byte_rx #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_in     (rx_in),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    logic       rst_q = 1'b0;
    int         wr_cyc[$];
    logic [7:0] wr_val[$];
    int         err_cyc[$];
    int         both_cnt = 0;
    int         hold_viol = 0;
    logic [7:0] prev_data = 8'h00;
    int         pass_cnt = 0;
    int         total_cnt = 0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    always @(negedge clk) begin
        if (wr_en) begin
            wr_cyc.push_back(cyc);
            wr_val.push_back(wr_data);
        end
        if (frame_err) err_cyc.push_back(cyc);
        if (wr_en && frame_err) both_cnt <= both_cnt + 1;
        if (rst_q && !wr_en && (wr_data !== prev_data)) hold_viol <= hold_viol + 1;
        prev_data <= wr_data;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_q();
        wr_cyc.delete();
        wr_val.delete();
        err_cyc.delete();
    endtask

    // Called on a negedge; leaves rx_in at the stop level when done.
    task automatic send_byte(input logic [7:0] d, input logic stop, output int start);
        rx_in = 1'b0;
        start = cyc;
        tick(C);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            tick(C);
        end
        rx_in = stop;
        tick(C);
    endtask

    function automatic int first_or(input int q[$]);
        return (q.size() > 0) ? q[0] : -1000;
    endfunction

    initial begin
        int s, s1, s2;
        vecs[0] = '{8'hA5, 1'b1, 8'hA5};
        vecs[1] = '{8'h00, 1'b1, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 8'hFF};
        vecs[3] = '{8'h66, 1'b0, 8'hFF};
        vecs[4] = '{8'h81, 1'b1, 8'h81};

        rst = 1'b0;
        tick(3);
        check("reset_busy", busy, 0);
        check("reset_wr_en", wr_en, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_wr_data", wr_data, 8'h00);
        rst = 1'b1;
        tick(5);

        for (int v = 0; v < 5; v++) begin
            clear_q();
            send_byte(vecs[v].data, vecs[v].stop, s);
            rx_in = 1'b1;
            tick(30);
            if (vecs[v].stop) begin
                check($sformatf("vec%0d_wr_count", v), wr_cyc.size(), 1);
                check($sformatf("vec%0d_err_count", v), err_cyc.size(), 0);
                check($sformatf("vec%0d_wr_latency", v), first_or(wr_cyc) - s, LAT);
                check($sformatf("vec%0d_wr_val", v), (wr_val.size() > 0) ? wr_val[0] : 8'hxx, vecs[v].data);
            end else begin
                check($sformatf("vec%0d_err_count", v), err_cyc.size(), 1);
                check($sformatf("vec%0d_wr_count", v), wr_cyc.size(), 0);
                check($sformatf("vec%0d_err_latency", v), first_or(err_cyc) - s, LAT);
            end
            check($sformatf("vec%0d_wr_data", v), wr_data, vecs[v].exp_data);
        end

        // Back-to-back frames with no idle gap
        clear_q();
        send_byte(8'h3C, 1'b1, s1);
        send_byte(8'hC3, 1'b1, s2);
        rx_in = 1'b1;
        tick(30);
        check("b2b_count", wr_cyc.size(), 2);
        check("b2b_first_latency", first_or(wr_cyc) - s1, LAT);
        check("b2b_spacing", (wr_cyc.size() > 1) ? wr_cyc[1] - wr_cyc[0] : -1, 160);
        check("b2b_val0", (wr_val.size() > 0) ? wr_val[0] : 8'hxx, 8'h3C);
        check("b2b_val1", (wr_val.size() > 1) ? wr_val[1] : 8'hxx, 8'hC3);

        // Short low glitch is rejected at the mid-start sample
        clear_q();
        rx_in = 1'b0;
        tick(4);
        rx_in = 1'b1;
        tick(2);
        check("glitch_busy_start", busy, 1);
        tick(6);
        check("glitch_back_idle", busy, 0);
        tick(30);
        check("glitch_no_wr", wr_cyc.size(), 0);
        check("glitch_no_err", err_cyc.size(), 0);
        check("glitch_wr_data", wr_data, 8'hC3);

        // Low stop bit followed by a break
        clear_q();
        send_byte(8'h5A, 1'b0, s);
        tick(40);
        check("break_busy", busy, 1);
        check("break_err_count", err_cyc.size(), 1);
        check("break_err_latency", first_or(err_cyc) - s, LAT);
        check("break_no_wr", wr_cyc.size(), 0);
        check("break_wr_data", wr_data, 8'hC3);
        rx_in = 1'b1;
        tick(5);
        check("break_released", busy, 0);
        tick(20);
        check("break_no_retrigger", wr_cyc.size() + err_cyc.size(), 1);

        // Reset pulse during data bit 4 of 0xFF
        clear_q();
        fork
            send_byte(8'hFF, 1'b1, s);
            begin
                tick(C * 5 + 8);
                rst = 1'b0;
                tick(1);
                check("midrst_busy", busy, 0);
                check("midrst_wr_en", wr_en, 0);
                check("midrst_frame_err", frame_err, 0);
                check("midrst_wr_data", wr_data, 8'h00);
                rst = 1'b1;
            end
        join
        rx_in = 1'b1;
        tick(30);
        check("midrst_no_pulse", wr_cyc.size() + err_cyc.size(), 0);
        clear_q();
        send_byte(8'h81, 1'b1, s);
        tick(30);
        check("after_rst_count", wr_cyc.size(), 1);
        check("after_rst_latency", first_or(wr_cyc) - s, LAT);
        check("after_rst_val", wr_data, 8'h81);

        check("never_both_pulses", both_cnt, 0);
        check("wr_data_hold", hold_viol, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
